// File: rtl/sprite_compositor.sv
// sprite_compositor: overlays NUM_SPRITES 1-bpp scaled sprites on a background colour.
// Two-stage pipeline: stage 1 resolves per-sprite opacity, stage 2 picks the colour.
// Position, colour and enable are double-buffered and commit on next_frame_i.
// Bitmaps are written directly and are not buffered.
// Optional feature: define SPRITE_COMPOSITOR_COLLISION_EN to get per-sprite collision flags.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 12,
    parameter int SPRITE_H    = 12,
    parameter int SCALE_LOG2  = 3,
    parameter int PIX_BITS    = 10,
    parameter int COORD_BITS  = 8,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [PIX_BITS-1:0]    pixel_x_i,
    input  logic [PIX_BITS-1:0]    pixel_y_i,
    input  logic                   active_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic                   next_frame_i,
    input  logic [5:0]             bg_color_i,
    input  logic                   cfg_we_i,
    input  logic [IDX_W+1:0]       cfg_addr_i,
    input  logic [7:0]             cfg_wdata_i,
    input  logic                   bmp_we_i,
    input  logic [IDX_W-1:0]       bmp_sprite_i,
    input  logic [3:0]             bmp_row_i,
    input  logic [SPRITE_W-1:0]    bmp_data_i,
    output logic [5:0]             rrggbb_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic [NUM_SPRITES-1:0] collision_o
);

    localparam int SX_W = PIX_BITS - SCALE_LOG2;
    // One spare bit above the wider operand so the subtraction sign is always valid.
    localparam int CW   = ((SX_W > COORD_BITS) ? SX_W : COORD_BITS) + 1;
    localparam int RW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int CLW  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [5:0] COL_RST = 6'b110001;

    // True when offset d (signed, CW bits) lies within [0, len).
    function automatic logic in_span(input logic [CW-1:0] d, input int len);
        return !d[CW-1] && (d < CW'(len));
    endfunction

    logic [COORD_BITS-1:0] r_pend_x   [NUM_SPRITES];
    logic [COORD_BITS-1:0] r_pend_y   [NUM_SPRITES];
    logic [5:0]            r_pend_col [NUM_SPRITES];
    logic                  r_pend_en  [NUM_SPRITES];
    logic [COORD_BITS-1:0] r_act_x    [NUM_SPRITES];
    logic [COORD_BITS-1:0] r_act_y    [NUM_SPRITES];
    logic [5:0]            r_act_col  [NUM_SPRITES];
    logic                  r_act_en   [NUM_SPRITES];
    logic [COORD_BITS-1:0] w_pnx      [NUM_SPRITES];
    logic [COORD_BITS-1:0] w_pny      [NUM_SPRITES];
    logic [5:0]            w_pnc      [NUM_SPRITES];
    logic                  w_pne      [NUM_SPRITES];
    logic [SPRITE_W-1:0]   r_bmp      [NUM_SPRITES][SPRITE_H];

    logic [IDX_W-1:0]       w_cfg_idx;
    logic [1:0]             w_cfg_fld;
    logic [SX_W-1:0]        w_sx, w_sy;
    logic [NUM_SPRITES-1:0] w_opq;
    logic [5:0]             w_pix;

    logic [NUM_SPRITES-1:0] r_opq_p1;
    logic                   r_act_p1, r_hs_p1, r_vs_p1;
    logic [5:0]             r_bg_p1;

    assign w_cfg_idx = cfg_addr_i[IDX_W+1:2];
    assign w_cfg_fld = cfg_addr_i[1:0];
    assign w_sx      = SX_W'(pixel_x_i >> SCALE_LOG2);
    assign w_sy      = SX_W'(pixel_y_i >> SCALE_LOG2);

    // Next pending values: current pending plus any register write this cycle.
    always_comb begin
        for (int s = 0; s < NUM_SPRITES; s++) begin
            w_pnx[s] = r_pend_x[s];
            w_pny[s] = r_pend_y[s];
            w_pnc[s] = r_pend_col[s];
            w_pne[s] = r_pend_en[s];
            if (cfg_we_i && (int'(w_cfg_idx) == s)) begin
                case (w_cfg_fld)
                    2'd0:    w_pnx[s] = COORD_BITS'(cfg_wdata_i);
                    2'd1:    w_pny[s] = COORD_BITS'(cfg_wdata_i);
                    2'd2:    w_pnc[s] = cfg_wdata_i[5:0];
                    default: w_pne[s] = cfg_wdata_i[0];
                endcase
            end
        end
    end

    // Pending registers track writes; active registers take the pending set at frame end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                r_pend_x[s]   <= '0;
                r_pend_y[s]   <= '0;
                r_pend_col[s] <= COL_RST;
                r_pend_en[s]  <= 1'b0;
                r_act_x[s]    <= '0;
                r_act_y[s]    <= '0;
                r_act_col[s]  <= COL_RST;
                r_act_en[s]   <= 1'b0;
            end
        end else begin
            for (int s = 0; s < NUM_SPRITES; s++) begin
                r_pend_x[s]   <= w_pnx[s];
                r_pend_y[s]   <= w_pny[s];
                r_pend_col[s] <= w_pnc[s];
                r_pend_en[s]  <= w_pne[s];
                if (next_frame_i) begin
                    r_act_x[s]   <= w_pnx[s];
                    r_act_y[s]   <= w_pny[s];
                    r_act_col[s] <= w_pnc[s];
                    r_act_en[s]  <= w_pne[s];
                end
            end
        end
    end

    // Bitmap rows are written straight through; out-of-range targets are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SPRITES; s++)
                for (int r = 0; r < SPRITE_H; r++)
                    r_bmp[s][r] <= '0;
        end else if (bmp_we_i && (int'(bmp_sprite_i) < NUM_SPRITES) &&
                     (int'(bmp_row_i) < SPRITE_H)) begin
            r_bmp[bmp_sprite_i][bmp_row_i[RW-1:0]] <= bmp_data_i;
        end
    end

    // Per-sprite opacity at the current pixel: enabled, inside the box, bitmap bit set.
    always_comb begin
        logic [CW-1:0]       w_dx, w_dy;
        logic [SPRITE_W-1:0] w_shift;
        w_opq = '0;
        for (int s = 0; s < NUM_SPRITES; s++) begin
            w_dx    = CW'(w_sx) - CW'(r_act_x[s]);
            w_dy    = CW'(w_sy) - CW'(r_act_y[s]);
            w_shift = r_bmp[s][w_dy[RW-1:0]] << w_dx[CLW-1:0];
            w_opq[s] = r_act_en[s] && in_span(w_dx, SPRITE_W) &&
                       in_span(w_dy, SPRITE_H) && w_shift[SPRITE_W-1];
        end
    end

    // ---- stage 1: opacity, background and syncs ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_opq_p1 <= '0;
            r_act_p1 <= 1'b0;
            r_hs_p1  <= 1'b0;
            r_vs_p1  <= 1'b0;
            r_bg_p1  <= '0;
        end else begin
            r_opq_p1 <= w_opq;
            r_act_p1 <= active_i;
            r_hs_p1  <= hsync_i;
            r_vs_p1  <= vsync_i;
            r_bg_p1  <= bg_color_i;
        end
    end

    // Lowest-index opaque sprite wins; blanking forces black.
    always_comb begin
        w_pix = r_bg_p1;
        for (int s = NUM_SPRITES - 1; s >= 0; s--)
            if (r_opq_p1[s]) w_pix = r_act_col[s];
        if (!r_act_p1) w_pix = '0;
    end

    // ---- stage 2: composited colour and delayed syncs ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rrggbb_o <= '0;
            hsync_o  <= 1'b0;
            vsync_o  <= 1'b0;
        end else begin
            rrggbb_o <= w_pix;
            hsync_o  <= r_hs_p1;
            vsync_o  <= r_vs_p1;
        end
    end

`ifdef SPRITE_COMPOSITOR_COLLISION_EN
    logic [NUM_SPRITES-1:0] r_coll_acc, w_coll_acc;

    // A sprite collides when it is opaque together with at least one other sprite.
    always_comb begin
        w_coll_acc = r_coll_acc;
        if (active_i && ((w_opq & (w_opq - NUM_SPRITES'(1))) != '0))
            w_coll_acc = r_coll_acc | w_opq;
    end

    // Publish the frame's collisions at frame end, including a same-cycle hit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_coll_acc  <= '0;
            collision_o <= '0;
        end else if (next_frame_i) begin
            collision_o <= w_coll_acc;
            r_coll_acc  <= '0;
        end else begin
            r_coll_acc  <= w_coll_acc;
        end
    end
`else
    assign collision_o = '0;
`endif

endmodule
